// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared FSM encoding and reset divider for the SD SPI master
package sd_spi_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  localparam logic [7:0] DIV_INIT_DEF = 8'd62;
endpackage

// File: rtl/sd_spi_master.sv
// sd_spi_master: SPI mode-0 byte master for SD cards; cmd/rsp handshake, cs/div strobes, sd_cs/sd_sck/sd_sdi/sd_sdo pins
module sd_spi_master
  import sd_spi_pkg::*;
#(
  parameter logic [7:0] DIV_INIT = DIV_INIT_DEF
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       cs_wr,
  input  logic       cs_val,
  input  logic       div_wr,
  input  logic [7:0] div_val,
  output logic       sd_cs,
  output logic       sd_sck,
  output logic       sd_sdi,
  input  logic       sd_sdo
);
  state_t state, state_n;
  logic [7:0] div_reg, div_lat, cnt, tx, rx;
  logic [2:0] bcnt;
  logic cs_pend, cs_pval;
  logic busy, phase_end, accept;
  assign busy = state == LOW || state == HIGH;
  assign phase_end = cnt == 8'd0;
  assign cmd_ready = !busy;
  assign accept = cmd_valid && cmd_ready;
  assign rsp_valid = state == DONE;
  assign rsp_data = rx;
  assign sd_sck = state == HIGH;
  assign sd_sdi = busy ? tx[7] : 1'b1;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = accept ? LOW : IDLE;
      LOW:        state_n = phase_end ? HIGH : LOW;
      HIGH:       state_n = phase_end ? (&bcnt ? DONE : LOW) : HIGH;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_reg <= DIV_INIT;
      div_lat <= 8'd0;
      cnt     <= 8'd0;
      tx      <= 8'd0;
      rx      <= 8'd0;
      bcnt    <= 3'd0;
      sd_cs   <= 1'b1;
      cs_pend <= 1'b0;
      cs_pval <= 1'b1;
    end else begin
      if (div_wr) div_reg <= div_val;
      if (accept) begin
        tx      <= cmd_data;
        div_lat <= div_reg;
        cnt     <= div_reg;
        bcnt    <= 3'd0;
      end else if (busy) begin
        cnt <= phase_end ? div_lat : cnt - 8'd1;
        if (state == LOW && phase_end) rx <= {rx[6:0], sd_sdo};
        if (state == HIGH && phase_end) begin
          tx   <= {tx[6:0], 1'b0};
          bcnt <= bcnt + 3'd1;
        end
      end
      // cs changes mid-byte are deferred so the card never sees CS move under a clocking byte
      if (!busy) begin
        if (cs_wr) sd_cs <= cs_val;
      end else if (state_n == DONE) begin
        sd_cs   <= cs_wr ? cs_val : cs_pend ? cs_pval : sd_cs;
        cs_pend <= 1'b0;
      end else if (cs_wr) begin
        cs_pend <= 1'b1;
        cs_pval <= cs_val;
      end
    end
  end
endmodule

// File: doc/sd_spi_master.md
SD_SPI_MASTER -- requirements
Module: sd_spi_master

Interface
REQ-001 SHALL have parameter DIV_INIT, default 8'd62, reset value of the internal divider register (25 MHz clk_sys -> ~198 kHz SCK for card init).
REQ-002 SHALL have port clk_sys  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  byte transfer request.
REQ-005 SHALL have port cmd_ready  output  1  master idle, transfer request accepted this cycle if cmd_valid=1.
REQ-006 SHALL have port cmd_data  input  8  byte to shift out, MSB first.
REQ-007 SHALL have port rsp_valid  output  1  one-cycle pulse, rsp_data valid.
REQ-008 SHALL have port rsp_data  output  8  byte shifted in from sd_sdo.
REQ-009 SHALL have port cs_wr  input  1  chip-select update strobe.
REQ-010 SHALL have port cs_val  input  1  new sd_cs level (0 = card selected).
REQ-011 SHALL have port div_wr  input  1  divider update strobe.
REQ-012 SHALL have port div_val  input  8  new divider; SCK half-period = div+1 clk_sys cycles.
REQ-013 SHALL have port sd_cs  output  1  card chip select, active low.
REQ-014 SHALL have port sd_sck  output  1  SPI clock, mode 0 (idle low).
REQ-015 SHALL have port sd_sdi  output  1  MOSI toward card.
REQ-016 SHALL have port sd_sdo  input  1  MISO from card.

Function
REQ-017 SHALL implement states IDLE, LOW, HIGH, DONE; cmd_ready=1 only in IDLE and DONE.
REQ-018 SHALL, on cmd_valid & cmd_ready at cycle T, latch cmd_data and current divider, enter LOW at T+1 with sd_sdi=bit7, sd_sck=0.
REQ-019 SHALL hold each LOW and HIGH phase exactly div+1 cycles via a down-counter reloaded at every phase entry.
REQ-020 SHALL drive sd_sck=1 in HIGH, sample sd_sdo into the receive shift register on the LOW->HIGH transition cycle.
REQ-021 SHALL shift the next MOSI bit onto sd_sdi on each HIGH->LOW transition; 8 LOW/HIGH pairs per byte.
REQ-022 SHALL enter DONE after the 8th HIGH phase, asserting rsp_valid for exactly one cycle at T+1+16*(div+1), sd_sck=0.
REQ-023 SHALL accept a new cmd in DONE (back-to-back), entering LOW next cycle with no idle gap.
REQ-024 SHALL drive sd_sdi=1 whenever not in LOW/HIGH.
REQ-025 SHALL apply cs_wr in IDLE/DONE on the next cycle; cs_wr during LOW/HIGH SHALL be held pending (last value wins) and applied in the DONE cycle.
REQ-026 SHALL, when cs_wr and accepted cmd occur in the same cycle, update sd_cs at T+1 together with the first LOW phase.
REQ-027 SHALL load div_wr into the divider register any time; an in-flight byte SHALL keep its latched divider.
REQ-028 SHALL support div=0 (sd_sck = clk_sys/2) and div=255 (half-period 256 cycles) with no counter wrap error.
REQ-029 SHALL ignore cmd_valid when cmd_ready=0; no queueing.

Reset
REQ-030 SHALL, on reset_n=0 (including mid-byte), asynchronously force IDLE, sd_cs=1, sd_sck=0, sd_sdi=1, cmd_ready=1, rsp_valid=0, rsp_data=8'h00, divider=DIV_INIT, pending CS cleared; aborted byte SHALL produce no rsp_valid.

Structure
REQ-031 SHALL take state encoding enum and DIV_INIT default from shared package sd_spi_pkg.
REQ-032 SHALL be a single module; optional sub-module sd_spi_clkgen (phase counter + tick) is the only natural split.

Verification
REQ-033 Reset, div=62, cs_wr cs_val=0, send 8'hFF with sd_sdo tied 1 -> sd_cs=0, rsp_valid at T+1+1008, rsp_data=8'hFF.
REQ-034 div=0, send 8'h40, card model returns 8'hA5 mode 0 -> sd_sdi pattern 0,1,0,0,0,0,0,0 on rising edges, rsp_data=8'hA5 at T+17.
REQ-035 Back-to-back 8'h12, 8'h34 with cmd_valid held -> second LOW starts cycle after first rsp_valid, no sck glitch, two rsp_valid pulses.
REQ-036 cs_wr cs_val=1 mid-byte -> sd_cs unchanged until DONE cycle, then 1.
REQ-037 div_wr div_val=3 mid-byte at div=1 -> current byte keeps 2-cycle half-period, next byte 4-cycle.
REQ-038 reset_n low during 4th HIGH phase -> immediate reset values, no rsp_valid, next cmd completes normally.
